// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - TileLink-UL opcodes, d_param bits and responder state enum
//
// Shared by tl_mem_responder and tl_mem_array.
//   TL_*             A/D channel opcode encodings
//   DP_NOUPD/DP_ERR  bit positions inside d_param
//   SOURCE_W         width of a_source/d_source
//   tl_resp_state_e  responder FSM state

package tl_pkg;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  localparam int DP_NOUPD = 0;
  localparam int DP_ERR   = 1;

  localparam int SOURCE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } tl_resp_state_e;

  function automatic logic tl_op_supported(input logic [2:0] op);
    return (op == TL_GET) || (op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/tl_mem_array.sv
// rtl/tl_mem_array.sv - DEPTH x 64 single-port RAM, byte write enables, registered read
//
// Ports:
//   clk    rising-edge clock
//   addr   word index
//   we/be  write strobe and per-byte lane enables (be[i] covers wdata[8i+7:8i])
//   wdata  write data
//   re     read strobe; rdata updates on the edge where re is high, then holds
//   rdata  registered read data

module tl_mem_array #(
  parameter int DEPTH     = 8192,
  parameter     INIT_FILE = "",
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  input  logic          re,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // rdata holds between reads so the responder can present it for the
  // whole RESP phase without a second copy.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/tl_mem_responder.sv
// rtl/tl_mem_responder.sv - TileLink-UL memory responder with programmable wait states
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_valid/a_ready             A-channel handshake
//   a_opcode/a_size/a_source    request type, size (legality only), master tag
//   a_address/a_mask/a_data     byte address, byte lanes, write data
//   d_valid/d_ready             D-channel handshake
//   d_opcode/d_param            AccessAck(Data); param[0]=no cache update, param[1]=error
//   d_size/d_source/d_data      echoed size and tag, read data (0 for acks and errors)

module tl_mem_responder
  import tl_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH       = 8192,
  parameter int          WAIT_STATES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [63:0]         a_address,
  input  logic [7:0]          a_mask,
  input  logic [63:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic [63:0]         d_data
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = BASE_ADDR + 64'(DEPTH) * 64'd8;

  tl_resp_state_e state, next_state;

  logic [3:0]    cnt;
  logic [2:0]    req_op;
  logic [AW-1:0] req_idx;
  logic [7:0]    req_mask;
  logic [63:0]   req_data;
  logic          req_err;
  logic          rd_flag;

  logic          accept;
  logic          terminal;
  logic          a_in_range;
  logic          a_err;
  logic [63:0]   a_offset;
  logic [AW-1:0] a_idx;
  logic          mem_we;
  logic          mem_re;
  logic [63:0]   mem_rdata;

  // Request decode, evaluated on the live A-channel so only the outcome is latched.
  always_comb begin
    a_offset   = a_address - BASE_ADDR;
    a_idx      = AW'(a_offset >> 3);
    a_in_range = (a_address >= BASE_ADDR) && (a_address < LIMIT);
    a_err      = !a_in_range || !tl_op_supported(a_opcode) || (a_size > 3'd3);
  end

  assign accept   = (state == ST_IDLE) && a_valid;
  // WAIT lasts WAIT_STATES+1 cycles; the RAM op fires on the last of them so
  // the registered read data is in place on the edge that enters RESP.
  assign terminal = (state == ST_WAIT) && (cnt == 4'(WAIT_STATES));

  always_comb begin
    next_state = state;
    a_ready    = 1'b0;
    d_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        a_ready = 1'b1;
        if (a_valid) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (terminal) next_state = ST_RESP;
      end
      ST_RESP: begin
        d_valid = 1'b1;
        if (d_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if ((state == ST_WAIT) && !terminal) cnt <= cnt + 4'd1;
      else                                 cnt <= '0;
    end
  end

  // D fields are loaded at accept and cannot change again until the
  // responder is back in IDLE, which keeps them stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_op   <= '0;
      req_idx  <= '0;
      req_mask <= '0;
      req_data <= '0;
      req_err  <= 1'b0;
      rd_flag  <= 1'b0;
      d_opcode <= '0;
      d_param  <= '0;
      d_size   <= '0;
      d_source <= '0;
    end else if (accept) begin
      req_op            <= a_opcode;
      req_idx           <= a_idx;
      req_mask          <= a_mask;
      req_data          <= a_data;
      req_err           <= a_err;
      rd_flag           <= (a_opcode == TL_GET) && !a_err;
      d_opcode          <= (a_opcode == TL_GET) ? TL_ACK_DATA : TL_ACK;
      d_param[DP_NOUPD] <= (a_opcode != TL_GET);
      d_param[DP_ERR]   <= a_err;
      d_size            <= a_size;
      d_source          <= a_source;
    end
  end

  assign mem_we = terminal && !req_err && (req_op != TL_GET);
  assign mem_re = terminal && !req_err && (req_op == TL_GET);
  assign d_data = rd_flag ? mem_rdata : 64'd0;

  tl_mem_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE),
    .AW        (AW)
  ) u_mem (
    .clk   (clk),
    .addr  (req_idx),
    .we    (mem_we),
    .be    (req_mask),
    .wdata (req_data),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_tl_mem_responder.sv
// tb/tb_tl_mem_responder.sv - scoreboard bench for tl_mem_responder

module tb_tl_mem_responder;
  import tl_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          DEP  = 8192;
  localparam int          WS   = 2;

  logic                clk;
  logic                rst_n;
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [63:0]         a_address;
  logic [7:0]          a_mask;
  logic [63:0]         a_data;
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [2:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic [63:0]         d_data;

  tl_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEP),
    .WAIT_STATES (WS),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_data    (d_data)
  );

  typedef struct {
    logic [2:0]          op;
    logic [1:0]          prm;
    logic [2:0]          sz;
    logic [SOURCE_W-1:0] src;
    logic [63:0]         data;
  } resp_t;

  resp_t exp_q[$];
  int    n_chk   = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    last_hs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every completed D handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && d_valid && d_ready) begin
      last_hs = cyc + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("d_opcode", 64'(d_opcode), 64'(e.op));
        chk("d_param",  64'(d_param),  64'(e.prm));
        chk("d_size",   64'(d_size),   64'(e.sz));
        chk("d_source", 64'(d_source), 64'(e.src));
        chk("d_data",   d_data,        e.data);
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [1:0] prm, input logic [2:0] sz,
                      input logic [SOURCE_W-1:0] src, input logic [63:0] data);
    resp_t e;
    e.op = op; e.prm = prm; e.sz = sz; e.src = src; e.data = data;
    exp_q.push_back(e);
  endtask

  // Leaves a_valid high so callers can present back-to-back requests.
  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [SOURCE_W-1:0] src,
                      input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                      output int acc_cyc);
    bit seen;
    bit done;
    int n;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
    done = 1'b0; n = 0;
    while (!done) begin
      @(negedge clk);
      seen = a_ready;
      @(posedge clk); #1;
      n++;
      if (seen) done = 1'b1;
      else if (n > 60) begin
        chk("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    acc_cyc = cyc;
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] sz, input logic [SOURCE_W-1:0] src,
                     input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                     input logic [2:0] e_op, input logic [1:0] e_prm, input logic [63:0] e_data);
    int acc;
    push(e_op, e_prm, sz, src, e_data);
    send(op, sz, src, addr, mask, data, acc);
    a_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, hs1, acc;
    rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = '0; a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready",  64'(a_ready),  64'd1);
    chk("rst_d_valid",  64'(d_valid),  64'd0);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    chk("rst_d_param",  64'(d_param),  64'd0);
    chk("rst_d_source", 64'(d_source), 64'd0);
    chk("rst_d_data",   d_data,        64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b1;

    // Full put then get, then a partial put over the low four lanes.
    req(TL_PUT_FULL,    3, 1, 64'h8000_0010, 8'hFF, 64'h1122334455667788, TL_ACK,      2'b01, 64'd0);
    req(TL_GET,         3, 2, 64'h8000_0010, 8'hFF, 64'd0,                TL_ACK_DATA, 2'b00, 64'h1122334455667788);
    req(TL_PUT_PARTIAL, 3, 3, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, TL_ACK,   2'b01, 64'd0);
    req(TL_GET,         3, 2, 64'h8000_0010, 8'hFF, 64'd0,                TL_ACK_DATA, 2'b00, 64'h11223344BBBBBBBB);

    // Address window edges and other error cases.
    req(TL_GET,      3, 4, 64'h7FFF_FFF8, 8'hFF, 64'd0, TL_ACK_DATA, 2'b10, 64'd0);
    req(TL_GET,      3, 5, 64'h8001_0000, 8'hFF, 64'd0, TL_ACK_DATA, 2'b10, 64'd0);
    req(TL_PUT_FULL, 3, 6, 64'h8000_FFF8, 8'hFF, 64'hCAFE_F00D_1234_5678, TL_ACK, 2'b01, 64'd0);
    req(TL_GET,      3, 7, 64'h8000_FFF8, 8'hFF, 64'd0, TL_ACK_DATA, 2'b00, 64'hCAFE_F00D_1234_5678);
    req(TL_PUT_FULL, 3, 1, 64'h8000_0000, 8'hFF, 64'h0A0B_0C0D_0E0F_1011, TL_ACK, 2'b01, 64'd0);
    req(TL_PUT_FULL, 3, 2, 64'h8001_0000, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, TL_ACK, 2'b11, 64'd0);
    req(3'd2,        3, 3, 64'h8000_0000, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, TL_ACK, 2'b11, 64'd0);
    req(TL_PUT_FULL, 4, 4, 64'h8000_0000, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, TL_ACK, 2'b11, 64'd0);
    req(TL_GET,      4, 5, 64'h8000_0000, 8'hFF, 64'd0, TL_ACK_DATA, 2'b10, 64'd0);
    req(TL_GET,      3, 6, 64'h8000_0000, 8'hFF, 64'd0, TL_ACK_DATA, 2'b00, 64'h0A0B_0C0D_0E0F_1011);
    drain();

    // Latency and D-field stability under back-pressure.
    d_ready = 1'b0;
    push(TL_ACK_DATA, 2'b00, 3, 6, 64'h11223344BBBBBBBB);
    send(TL_GET, 3, 6, 64'h8000_0010, 8'hFF, 64'd0, acc);
    a_valid = 1'b0;
    @(negedge clk); chk("lat_edge0", 64'(d_valid), 64'd0);
    @(negedge clk); chk("lat_edge1", 64'(d_valid), 64'd0);
    @(negedge clk); chk("lat_edge2", 64'(d_valid), 64'd0);
    @(negedge clk); chk("lat_edge3", 64'(d_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_d_valid",  64'(d_valid),  64'd1);
      chk("hold_a_ready",  64'(a_ready),  64'd0);
      chk("hold_d_opcode", 64'(d_opcode), 64'(TL_ACK_DATA));
      chk("hold_d_param",  64'(d_param),  64'd0);
      chk("hold_d_source", 64'(d_source), 64'd6);
      chk("hold_d_data",   d_data,        64'h11223344BBBBBBBB);
    end
    d_ready = 1'b1;
    drain();

    // Back-to-back gets with a_valid held high across both.
    push(TL_ACK_DATA, 2'b00, 3, 3, 64'h11223344BBBBBBBB);
    push(TL_ACK_DATA, 2'b00, 3, 5, 64'h11223344BBBBBBBB);
    send(TL_GET, 3, 3, 64'h8000_0010, 8'hFF, 64'd0, acc1);
    send(TL_GET, 3, 5, 64'h8000_0010, 8'hFF, 64'd0, acc2);
    hs1 = last_hs;
    a_valid = 1'b0;
    drain();
    chk("b2b_spacing",  64'(acc2 - acc1), 64'(WS + 3));
    chk("b2b_after_hs", 64'(acc2),        64'(hs1 + 1));

    // Reset while a put sits in WAIT: the write must never land.
    req(TL_PUT_FULL, 3, 1, 64'h8000_0020, 8'hFF, 64'h0102_0304_0506_0708, TL_ACK, 2'b01, 64'd0);
    drain();
    d_ready = 1'b0;
    send(TL_PUT_FULL, 3, 2, 64'h8000_0020, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, acc);
    a_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_d_valid", 64'(d_valid), 64'd0);
    chk("rst_wait_a_ready", 64'(a_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b1;
    req(TL_GET, 3, 3, 64'h8000_0020, 8'hFF, 64'd0, TL_ACK_DATA, 2'b00, 64'h0102_0304_0506_0708);
    drain();

    // Reset while a get is held in RESP: response dropped, RAM untouched.
    d_ready = 1'b0;
    send(TL_GET, 3, 4, 64'h8000_0020, 8'hFF, 64'd0, acc);
    a_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_d_valid", 64'(d_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_d_valid", 64'(d_valid), 64'd0);
    chk("rst_resp_a_ready", 64'(a_ready), 64'd1);
    chk("rst_resp_d_data",  d_data,       64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b1;
    req(TL_GET, 3, 5, 64'h8000_0020, 8'hFF, 64'd0, TL_ACK_DATA, 2'b00, 64'h0102_0304_0506_0708);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
